// File: rtl/seven_seg_scan_controller.sv
// Multiplexed 7-segment scan controller: walks NUM_DIGITS common-anode digits,
// feeds one shared registered BCD decoder and drives active-low anodes with a guard band.
module seven_seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0]   i_Digits,
  input  logic [NUM_DIGITS-1:0]     i_Blink_Mask,
  input  logic                      i_Blink_Tick,
  input  logic                      i_LZ_Blank_En,
  output logic [3:0]                o_BCD_Num,
  output logic [NUM_DIGITS-1:0]     o_Anodes,
  output logic                      o_Colon,
  output logic                      o_Frame_Start
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  logic [DIV_W-1:0]      r_Div;
  logic [IDX_W-1:0]      r_Idx;
  logic [DIG_W-1:0]      r_Shadow;
  logic                  r_Phase;

  logic                  w_Div_Wrap;
  logic                  w_Idx_Wrap;
  logic [DIV_W-1:0]      w_Div_next;
  logic [IDX_W-1:0]      w_Idx_next;
  logic [DIG_W-1:0]      w_Shadow_next;
  logic                  w_Phase_next;
  logic [3:0]            w_Digit_Val;
  logic                  w_Mask_Bit;
  logic                  w_Blank;
  logic [NUM_DIGITS-1:0] w_Anodes_next;

  // Slot divider and digit index; wraps are explicit compares, never overflow.
  always_comb begin
    w_Div_Wrap = (r_Div == DIV_W'(SCAN_DIV - 1));
    w_Idx_Wrap = w_Div_Wrap && (r_Idx == IDX_W'(NUM_DIGITS - 1));
    w_Div_next = w_Div_Wrap ? '0 : r_Div + DIV_W'(1);
    w_Idx_next = r_Idx;
    if (w_Div_Wrap) begin
      w_Idx_next = w_Idx_Wrap ? '0 : r_Idx + IDX_W'(1);
    end
    w_Shadow_next = w_Idx_Wrap ? i_Digits : r_Shadow;
    w_Phase_next  = r_Phase ^ i_Blink_Tick;
  end

  // Digit value and blink bit for the slot the registers are about to enter.
  always_comb begin
    w_Digit_Val = 4'h0;
    w_Mask_Bit  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (w_Idx_next == IDX_W'(k)) begin
        w_Digit_Val = w_Shadow_next[4*k +: 4];
        w_Mask_Bit  = i_Blink_Mask[k];
      end
    end
  end

  always_comb begin
    w_Blank = (w_Phase_next && w_Mask_Bit)
           || (i_LZ_Blank_En && (w_Idx_next == IDX_W'(NUM_DIGITS - 1)) && (w_Digit_Val == 4'h0))
           || (w_Digit_Val > 4'd9);
    w_Anodes_next = '1;
    // Anodes stay off through the guard band so the decoder has settled first.
    if ((w_Div_next >= DIV_W'(BLANK_CYCLES)) && !w_Blank) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (w_Idx_next == IDX_W'(k)) begin
          w_Anodes_next[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Div         <= '0;
      r_Idx         <= '0;
      r_Shadow      <= '0;
      r_Phase       <= 1'b0;
      o_BCD_Num     <= 4'h0;
      o_Anodes      <= '1;
      o_Colon       <= 1'b1;
      o_Frame_Start <= 1'b0;
    end else begin
      r_Div         <= w_Div_next;
      r_Idx         <= w_Idx_next;
      r_Shadow      <= w_Shadow_next;
      r_Phase       <= w_Phase_next;
      o_BCD_Num     <= w_Digit_Val;
      o_Anodes      <= w_Anodes_next;
      o_Colon       <= ~w_Phase_next;
      o_Frame_Start <= w_Idx_Wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with SCAN_DIV=8, BLANK_CYCLES=2, 4 digits.
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blink_mask = 4'b0000;
  logic        blink_tick = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  anodes;
  logic        colon;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seven_seg_scan_controller #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Digits     (digits),
    .i_Blink_Mask (blink_mask),
    .i_Blink_Tick (blink_tick),
    .i_LZ_Blank_En(lz_en),
    .o_BCD_Num    (bcd),
    .o_Anodes     (anodes),
    .o_Colon      (colon),
    .o_Frame_Start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  // One 8-clock slot: 2 dark guard clocks, then exp_an for 6 clocks.
  task automatic slot(input string tag, input logic [3:0] exp_an, input logic [3:0] exp_bcd,
                      input logic exp_fs, input logic exp_colon, input logic tick_first);
    for (int k = 0; k < 8; k++) begin
      if (k == 0 && tick_first) blink_tick = 1'b1;
      step();
      blink_tick = 1'b0;
      chk({tag, "_an"},    32'(anodes),      (k < 2) ? 32'hF : 32'(exp_an));
      chk({tag, "_bcd"},   32'(bcd),         32'(exp_bcd));
      chk({tag, "_fs"},    32'(frame_start), (k == 0) ? 32'(exp_fs) : 32'h0);
      chk({tag, "_colon"}, 32'(colon),       32'(exp_colon));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an",    32'(anodes),      32'hF);
    chk("rst_bcd",   32'(bcd),         32'h0);
    chk("rst_colon", 32'(colon),       32'h1);
    chk("rst_fs",    32'(frame_start), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Frame 0 runs on the reset shadow (all zeros).
    step();
    chk("f0_guard_an", 32'(anodes), 32'hF);
    step();
    chk("f0_first_an", 32'(anodes), 32'hE);
    chk("f0_first_bcd", 32'(bcd), 32'h0);
    step_to(31);

    // Frame 1: 1234 loaded at the frame edge.
    slot("f1d0", 4'hE, 4'h4, 1'b1, 1'b1, 1'b0);
    slot("f1d1", 4'hD, 4'h3, 1'b0, 1'b1, 1'b0);
    slot("f1d2", 4'hB, 4'h2, 1'b0, 1'b1, 1'b0);
    slot("f1d3", 4'h7, 4'h1, 1'b0, 1'b1, 1'b0);

    // Frame 2: new digits mid-frame must not tear.
    slot("f2d0", 4'hE, 4'h4, 1'b1, 1'b1, 1'b0);
    slot("f2d1", 4'hD, 4'h3, 1'b0, 1'b1, 1'b0);
    digits = 16'h5678;
    slot("f2d2", 4'hB, 4'h2, 1'b0, 1'b1, 1'b0);
    slot("f2d3", 4'h7, 4'h1, 1'b0, 1'b1, 1'b0);
    slot("f3d0", 4'hE, 4'h8, 1'b1, 1'b1, 1'b0);
    slot("f3d1", 4'hD, 4'h7, 1'b0, 1'b1, 1'b0);
    slot("f3d2", 4'hB, 4'h6, 1'b0, 1'b1, 1'b0);
    slot("f3d3", 4'h7, 4'h5, 1'b0, 1'b1, 1'b0);

    // Leading-zero blanking on, then off.
    digits = 16'h0930;
    lz_en  = 1'b1;
    slot("lz1d0", 4'hE, 4'h0, 1'b1, 1'b1, 1'b0);
    slot("lz1d1", 4'hD, 4'h3, 1'b0, 1'b1, 1'b0);
    slot("lz1d2", 4'hB, 4'h9, 1'b0, 1'b1, 1'b0);
    slot("lz1d3", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
    lz_en = 1'b0;
    slot("lz0d0", 4'hE, 4'h0, 1'b1, 1'b1, 1'b0);
    slot("lz0d1", 4'hD, 4'h3, 1'b0, 1'b1, 1'b0);
    slot("lz0d2", 4'hB, 4'h9, 1'b0, 1'b1, 1'b0);
    slot("lz0d3", 4'h7, 4'h0, 1'b0, 1'b1, 1'b0);

    // Blink: tick lands on the wrap edge and applies to that slot.
    blink_mask = 4'b0011;
    slot("bk1d0", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
    slot("bk1d1", 4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
    slot("bk1d2", 4'hB, 4'h9, 1'b0, 1'b0, 1'b0);
    slot("bk1d3", 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);
    slot("bk0d0", 4'hE, 4'h0, 1'b1, 1'b1, 1'b1);
    slot("bk0d1", 4'hD, 4'h3, 1'b0, 1'b1, 1'b0);
    slot("bk0d2", 4'hB, 4'h9, 1'b0, 1'b1, 1'b0);
    slot("bk0d3", 4'h7, 4'h0, 1'b0, 1'b1, 1'b0);

    // Tick mid-slot blanks the lit digit at the next update.
    step_to(259);
    chk("mid_pre_an", 32'(anodes), 32'hE);
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    chk("mid_post_an",    32'(anodes), 32'hF);
    chk("mid_post_colon", 32'(colon),  32'h0);
    step_to(287);

    // Invalid code 0xA in digit 1 is never lit.
    blink_mask = 4'b0000;
    digits     = 16'h00A0;
    slot("inv_d0", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
    slot("inv_d1", 4'hF, 4'hA, 1'b0, 1'b0, 1'b0);
    slot("inv_d2", 4'hB, 4'h0, 1'b0, 1'b0, 1'b0);
    slot("inv_d3", 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while digit 2 is lit.
    step_to(340);
    chk("prerst_an", 32'(anodes), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("arst_an",    32'(anodes),      32'hF);
    chk("arst_bcd",   32'(bcd),         32'h0);
    chk("arst_colon", 32'(colon),       32'h1);
    chk("arst_fs",    32'(frame_start), 32'h0);
    @(posedge clk);
    #1;
    chk("hold_an", 32'(anodes), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rel1_an", 32'(anodes), 32'hF);
    step();
    chk("rel2_an",  32'(anodes), 32'hE);
    chk("rel2_bcd", 32'(bcd),    32'h0);
    chk("rel2_fs",  32'(frame_start), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
- Time-multiplexes one shared registered BCD-to-7-segment decoder (1-cycle latency) across NUM_DIGITS common-anode digits of the alarm-clock display.
- Selects one digit per slot and presents its BCD value to the decoder. Drives active-low anodes with a ghosting guard band.
- Applies blink, leading-zero and invalid-code blanking, and toggles the colon.
- Sits between the timekeeping/alarm-set logic and the display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- SCAN_DIV, 100000: clocks per digit slot (1 kHz/digit at 100 MHz).
- BLANK_CYCLES, 16: guard clocks at the start of each slot with all anodes off. Must satisfy 2 <= BLANK_CYCLES < SCAN_DIV. Covers the decoder latency.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Digits  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = rightmost; digit NUM_DIGITS-1 = most significant.
- i_Blink_Mask  in  NUM_DIGITS  1 = digit blinks (time-set mode).
- i_Blink_Tick  in  1  single-cycle pulse from the timebase; toggles blink phase.
- i_LZ_Blank_En  in  1  1 = blank the most significant digit when it is 0.
- o_BCD_Num  out  4  BCD to the shared decoder input.
- o_Anodes  out  NUM_DIGITS  active-low digit enables; bit k = digit k.
- o_Colon  out  1  colon segment, high = lit.
- o_Frame_Start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (async assert, sync release):
  - r_Div=0, r_Idx=0, shadow=0, r_Phase=0.
  - o_BCD_Num=0, o_Anodes=all 1, o_Frame_Start=0.
  - o_Colon=1, since o_Colon = ~r_Phase.
- Reset mid-scan aborts the slot immediately: anodes go all off in the same instant, with no clock needed.
- Divider: r_Div counts 0..SCAN_DIV-1 and wraps to 0. At the wrap, r_Idx advances by 1, wrapping NUM_DIGITS-1 -> 0.
- Frame load:
  - On the edge where r_Idx wraps to 0, shadow <= i_Digits and o_Frame_Start <= 1 for one cycle.
  - i_Digits changes at any other time have no effect until the next frame. No tearing within a frame.
- o_BCD_Num is registered and updates on the same edge r_Idx changes.
  - For the new index 0 it uses the i_Digits value being loaded, not the old shadow.
- o_Anodes is registered from the next-state values (r_Div_next, r_Idx_next):
  - all 1 while r_Div_next < BLANK_CYCLES;
  - otherwise only bit r_Idx_next is 0, unless that digit is blanked.
  - Lit time per slot = SCAN_DIV-BLANK_CYCLES clocks.
  - The decoder output is therefore stable (>=1 cycle settled) before any anode is enabled.
- Blank conditions (OR'd, evaluated on the current digit value and r_Phase):
  - (a) r_Phase=1 and i_Blink_Mask[idx]=1;
  - (b) i_LZ_Blank_En=1, idx=NUM_DIGITS-1 and value=0;
  - (c) value > 9.
- Blanked digit keeps all anodes high for the whole slot. o_BCD_Num still updates.
- Blink phase: r_Phase toggles on each cycle i_Blink_Tick=1. It is independent of slot boundaries, so blanking takes effect at the next anode-register update.
- Simultaneous i_Blink_Tick and slot wrap: both apply on the same edge. The anode decision uses the toggled phase.
- i_Blink_Mask and i_LZ_Blank_En are sampled live, not shadowed.
- Widths:
  - r_Div is clog2(SCAN_DIV) bits;
  - r_Idx is clog2(NUM_DIGITS) bits, minimum 1;
  - no arithmetic overflow is possible; the wrap is an explicit compare.

Test Plan:
1. SCAN_DIV=8, BLANK_CYCLES=2, i_Digits=16'h1234, no blanking:
   - anodes cycle 1110, 1101, 1011, 0111;
   - each lit 6 clocks after 2 all-off clocks;
   - o_BCD_Num 4, 3, 2, 1 aligned to slot start;
   - o_Frame_Start pulses once per 32 clocks.
2. Change i_Digits to 16'h5678 mid-frame at digit 2:
   - digits 2 and 3 still show 2 and 1;
   - o_BCD_Num=8 on the next frame-start edge;
   - then 7, 6, 5.
3. i_Digits=16'h0930, i_LZ_Blank_En=1:
   - digit 3 slot keeps o_Anodes=1111 for all 8 clocks;
   - with i_LZ_Blank_En=0, digit 3 lights (0111) showing 0.
4. i_Blink_Mask=4'b0011, pulse i_Blink_Tick:
   - o_Colon goes 1->0;
   - digits 0/1 slots stay dark and digits 2/3 light;
   - a second tick restores digits 0/1 and sets o_Colon=1;
   - a tick coinciding with a slot wrap applies to that slot.
5. i_Digits=16'h00A0:
   - digit 1 (value 10) is never lit;
   - the other digits are unaffected.
6. Assert i_Rst_L=0 while digit 2 is lit:
   - o_Anodes=1111 and o_BCD_Num=0 without a clock edge;
   - after release, scan restarts at digit 0, with first anode low at clock BLANK_CYCLES.
